// File: rtl/mmio_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus an MMIO page
// with an output FIFO and, when MMIO_TIMER_EN is defined, a timer with compare interrupt.
module mmio_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [14:0]   RAM_LIMIT = 15'(RAM_WORDS);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          unused_bits;

  assign ram_hit     = (a[31:16] == 16'h0) && ({1'b0, a[15:2]} < RAM_LIMIT);
  assign ram_idx     = a[AW+1:2];
  assign mmio_hit    = (a[31:4] == 28'hFFFF000);
  assign reg_sel     = a[3:2];
  assign unused_bits = ^a[1:0];

  logic wr_status;
  logic push;
  assign wr_status = we && mmio_hit && (reg_sel == 2'd2);
  assign push      = we && mmio_hit && (reg_sel == 2'd3);

  always_ff @(posedge clk) begin
    if (we && ram_hit) ram[ram_idx] <= wd;
  end

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] head;
  logic [FW-1:0] tail;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          accept;
  logic          ovf;

  assign full      = (count == DEPTH);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign accept    = push && (!full || pop);
  assign out_data  = out_valid ? fifo_mem[head] : 32'h0;

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[tail] <= wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pop)    head <= head + 1'b1;
      if (accept) tail <= tail + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)     ovf <= 1'b1;
      else if (wr_status && wd[3])  ovf <= 1'b0;
    end
  end

  logic [31:0] tcount_rd;
  logic [31:0] tcmp_rd;
  logic        tflag;

`ifdef MMIO_TIMER_EN
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        wr_tcount;
  logic        wr_tcmp;

  assign wr_tcount = we && mmio_hit && (reg_sel == 2'd0);
  assign wr_tcmp   = we && mmio_hit && (reg_sel == 2'd1);

  // A compare match outranks a same-cycle W1C so no interrupt is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount <= 32'h0;
      tcmp   <= 32'hFFFF_FFFF;
      tflag  <= 1'b0;
    end else begin
      tcount <= wr_tcount ? wd : tcount + 32'd1;
      if (wr_tcmp) tcmp <= wd;
      if (tcount == tcmp)           tflag <= 1'b1;
      else if (wr_status && wd[2])  tflag <= 1'b0;
    end
  end

  assign tcount_rd = tcount;
  assign tcmp_rd   = tcmp;
`else
  assign tcount_rd = 32'h0;
  assign tcmp_rd   = 32'h0;
  assign tflag     = 1'b0;
`endif

  assign irq = tflag;

  always_comb begin
    rd = 32'h0;
    if (ram_hit) begin
      rd = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        2'd0:    rd = tcount_rd;
        2'd1:    rd = tcmp_rd;
        2'd2:    rd = {16'h0, 8'(count), 4'h0, ovf, tflag, full, ~out_valid};
        default: rd = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder against a queue/array reference model;
// follows MMIO_TIMER_EN so it fits either build.
module tb_mmio_responder;

  localparam int RAM_WORDS  = 256;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] TCOUNT_A = 32'hFFFF_0000;
  localparam logic [31:0] TCMP_A   = 32'hFFFF_0004;
  localparam logic [31:0] STATUS_A = 32'hFFFF_0008;
  localparam logic [31:0] TX_A     = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        we = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] wd = 32'h0;
  logic        out_ready = 1'b0;
  logic [31:0] rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [int];
  logic [31:0] m_q [$];
  logic [31:0] m_tcount;
  logic [31:0] m_tcmp;
  bit          m_tflag;
  bit          m_ovf;

  always #5 clk = ~clk;

  mmio_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  function automatic logic [31:0] model_status();
    int n = m_q.size();
    return {16'h0, 8'(n), 4'h0, m_ovf, m_tflag, (n == FIFO_DEPTH), (n == 0)};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (addr < 32'(RAM_WORDS * 4)) begin
      if (m_ram.exists(int'(addr >> 2))) return m_ram[int'(addr >> 2)];
      return 32'hx;
    end
    if ((addr & 32'hFFFF_FFF0) != 32'hFFFF_0000) return 32'h0;
    case (addr[3:2])
`ifdef MMIO_TIMER_EN
      2'd0: return m_tcount;
      2'd1: return m_tcmp;
`endif
      2'd2: return model_status();
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_tcount = 32'h0;
    m_tcmp   = 32'hFFFF_FFFF;
    m_tflag  = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Advance the reference state by one clock using the inputs present at the edge.
  task automatic model_edge();
    bit pop = (m_q.size() != 0) && out_ready;
    bit full = (m_q.size() == FIFO_DEPTH);
    bit match = (m_tcount == m_tcmp);
    bit push = 1'b0;
    bit w1c = 1'b0;
    logic [31:0] next_cnt = m_tcount + 32'd1;
    if (we) begin
      if (a < 32'(RAM_WORDS * 4)) m_ram[int'(a >> 2)] = wd;
      else if ((a & 32'hFFFF_FFF0) == 32'hFFFF_0000) begin
        case (a[3:2])
          2'd0: next_cnt = wd;
          2'd1: m_tcmp = wd;
          2'd2: w1c = 1'b1;
          default: push = 1'b1;
        endcase
      end
    end
`ifdef MMIO_TIMER_EN
    if (match) m_tflag = 1'b1;
    else if (w1c && wd[2]) m_tflag = 1'b0;
    m_tcount = next_cnt;
`endif
    if (push && full && !pop) m_ovf = 1'b1;
    else if (w1c && wd[3]) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push && (!full || pop)) m_q.push_back(wd);
  endtask

  task automatic drive(input bit w, input logic [31:0] addr, input logic [31:0] data, input bit rdy);
    we = w; a = addr; wd = data; out_ready = rdy;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(0, STATUS_A, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp 00000001", rd); end
    drive(0, TCMP_A, 0, 0);
    checks++; if (rd !== model_rd(TCMP_A)) begin errors++; $display("FAIL reset_tcmp got %h exp %h", rd, model_rd(TCMP_A)); end
    reset = 1'b0;
    drive(0, TCOUNT_A, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tcount_start got %h exp 0", rd); end
    clock_edge();
    checks++; if (rd !== model_rd(TCOUNT_A)) begin errors++; $display("FAIL tcount_first got %h exp %h", rd, model_rd(TCOUNT_A)); end
  endtask

  task automatic test_ram();
    drive(1, 32'h0, 32'h1111_1111, 0); clock_edge();
    drive(1, 32'h10, 32'hDEAD_BEEF, 0); clock_edge();
    drive(0, 32'h10, 0, 0);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd10 got %h exp deadbeef", rd); end
    drive(0, 32'h13, 0, 0);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd13 got %h exp deadbeef", rd); end
    drive(0, 32'h1000, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_unmapped got %h exp 0", rd); end
    drive(1, 32'h1000, 32'h1234_5678, 0); clock_edge();
    drive(0, 32'h0, 0, 0);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL ram_alias0 got %h exp 11111111", rd); end
    drive(0, 32'h10, 0, 0);
    checks++; if (rd !== model_rd(32'h10)) begin errors++; $display("FAIL ram_keep got %h exp %h", rd, model_rd(32'h10)); end
  endtask

  task automatic test_fifo_fill_drain();
    for (int i = 1; i <= 9; i++) begin drive(1, TX_A, 32'(i), 0); clock_edge(); end
    drive(0, STATUS_A, 0, 0);
    checks++; if (rd !== 32'h0000_080A) begin errors++; $display("FAIL fill_status got %h exp 0000080a", rd); end
    checks++; if (rd !== model_status()) begin errors++; $display("FAIL fill_model got %h exp %h", rd, model_status()); end
    for (int i = 1; i <= 8; i++) begin
      drive(0, STATUS_A, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++; $display("FAIL drain_word got v=%b %h exp v=1 %h", out_valid, out_data, 32'(i));
      end
      clock_edge();
    end
    drive(0, STATUS_A, 0, 0);
    checks++; if (rd[0] !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %h v=%b exp empty", rd, out_valid); end
    drive(1, STATUS_A, 32'h8, 0); clock_edge();
    drive(0, STATUS_A, 0, 0);
    checks++; if (rd !== 32'h1 || rd !== model_status()) begin errors++; $display("FAIL ovf_clear got %h exp %h", rd, model_status()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin drive(1, TX_A, 32'h100 + 32'(i), 0); clock_edge(); end
    drive(1, TX_A, 32'hAA, 1);
    checks++; if (out_data !== 32'h100) begin errors++; $display("FAIL b2b_head got %h exp 00000100", out_data); end
    clock_edge();
    drive(0, STATUS_A, 0, 0);
    checks++; if (rd !== 32'h0000_0802) begin errors++; $display("FAIL b2b_status got %h exp 00000802", rd); end
    for (int k = 1; k <= 8; k++) begin
      drive(0, STATUS_A, 0, 1);
      checks++; if (out_data !== ((k == 8) ? 32'hAA : 32'h100 + 32'(k))) begin
        errors++; $display("FAIL b2b_order k=%0d got %h exp %h", k, out_data, m_q[0]);
      end
      clock_edge();
    end
    drive(0, STATUS_A, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer();
    drive(1, TCOUNT_A, 32'd1000, 0); clock_edge();
    drive(1, TCMP_A, 32'd20, 0); clock_edge();
    drive(1, STATUS_A, 32'h4, 0); clock_edge();
    drive(1, TCOUNT_A, 32'd10, 0); clock_edge();
    for (int k = 1; k <= 13; k++) begin
      drive(0, STATUS_A, 0, 0);
      clock_edge();
      checks++; if (irq !== (k >= 11)) begin errors++; $display("FAIL timer_irq k=%0d got %b exp %b", k, irq, (k >= 11)); end
    end
    checks++; if (rd !== model_status()) begin errors++; $display("FAIL timer_status got %h exp %h", rd, model_status()); end
    drive(1, STATUS_A, 32'h4, 0); clock_edge();
    drive(0, STATUS_A, 0, 0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timer_w1c got %b exp 0", irq); end
    drive(1, TCOUNT_A, 32'hFFFF_FFFF, 0); clock_edge();
    drive(0, TCOUNT_A, 0, 0);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_load got %h exp ffffffff", rd); end
    clock_edge();
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h exp 0", rd); end
  endtask
`else
  task automatic test_timer_disabled();
    drive(1, TCMP_A, 32'd123, 0); clock_edge();
    drive(0, TCMP_A, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL notimer_tcmp got %h exp 0", rd); end
    drive(0, TCOUNT_A, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL notimer_tcount got %h exp 0", rd); end
    for (int k = 0; k < 100; k++) begin
      drive(0, STATUS_A, 0, 0);
      checks++; if (irq !== 1'b0 || rd[2] !== 1'b0) begin errors++; $display("FAIL notimer_irq k=%0d got %b/%b exp 0", k, irq, rd[2]); end
      clock_edge();
    end
  endtask
`endif

  task automatic test_async_reset();
    drive(1, TCMP_A, 32'd5, 0); clock_edge();
    drive(1, TCOUNT_A, 32'd5, 0); clock_edge();
    drive(0, STATUS_A, 0, 0); clock_edge();
    checks++; if (irq !== m_tflag) begin errors++; $display("FAIL areset_pre_irq got %b exp %b", irq, m_tflag); end
    for (int i = 0; i < 3; i++) begin drive(1, TX_A, 32'h50 + 32'(i), 0); clock_edge(); end
    drive(0, STATUS_A, 0, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", out_valid); end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || irq !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL areset_drop got v=%b irq=%b d=%h exp 0", out_valid, irq, out_data);
    end
    clock_edge();
    reset = 1'b0;
    drive(0, STATUS_A, 0, 0);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL areset_status got %h exp 00000001", rd); end
    drive(0, TCOUNT_A, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL areset_tcount0 got %h exp 0", rd); end
    clock_edge();
    checks++; if (rd !== model_rd(TCOUNT_A)) begin errors++; $display("FAIL areset_tcount1 got %h exp %h", rd, model_rd(TCOUNT_A)); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] data;
    bit w;
    for (int i = 0; i < 16; i++) begin drive(1, 32'(i * 4), $urandom, 0); clock_edge(); end
    for (int n = 0; n < 300; n++) begin
      w = 1'b0; data = $urandom;
      case ($urandom_range(0, 9))
        0, 1: begin w = 1'b1; addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)); end
        2:    addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        3, 4: begin w = 1'b1; addr = TX_A; end
        5:    addr = STATUS_A;
        6:    begin w = 1'b1; addr = STATUS_A; data = 32'($urandom_range(0, 15)); end
        7:    addr = TCOUNT_A;
        8:    begin w = 1'b1; addr = TCMP_A; data = m_tcount + 32'($urandom_range(1, 6)); end
        default: begin w = $urandom_range(0, 1) == 1; addr = $urandom_range(0, 1) == 1 ? TCOUNT_A : 32'h0001_0000; end
      endcase
      drive(w, addr, data, $urandom_range(0, 1) == 1);
      checks++; if (rd !== model_rd(addr)) begin errors++; $display("FAIL rand_rd n=%0d a=%h got %h exp %h", n, addr, rd, model_rd(addr)); end
      checks++; if (out_valid !== (m_q.size() != 0) || out_data !== ((m_q.size() != 0) ? m_q[0] : 32'h0)) begin
        errors++; $display("FAIL rand_fifo n=%0d got v=%b %h exp size=%0d", n, out_valid, out_data, m_q.size());
      end
      checks++; if (irq !== m_tflag) begin errors++; $display("FAIL rand_irq n=%0d got %b exp %b", n, irq, m_tflag); end
      clock_edge();
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_fill_drain();
    test_back_to_back();
`ifdef MMIO_TIMER_EN
    test_timer();
`else
    test_timer_disabled();
`endif
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
